// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the unified memory path: access-size codes used by the
// memory, LSU and arbiter, the arbiter priority state, and size helpers.
package riscv_mem_pkg;

    localparam logic [2:0] SIZE_WORD   = 3'b000;
    localparam logic [2:0] SIZE_BYTE   = 3'b001;
    localparam logic [2:0] SIZE_HALF   = 3'b010;
    localparam logic [2:0] SIZE_BYTE_U = 3'b011;
    localparam logic [2:0] SIZE_HALF_U = 3'b100;

    typedef enum logic [0:0] {
        D_PRI = 1'b0,
        I_PRI = 1'b1
    } arb_state_e;

    // Number of bytes touched by an access; 0 marks an unsupported size code.
    function automatic logic [2:0] size_nbytes(input logic [2:0] size);
        logic [2:0] n;
        case (size)
            SIZE_WORD:              n = 3'd4;
            SIZE_BYTE, SIZE_BYTE_U: n = 3'd1;
            SIZE_HALF, SIZE_HALF_U: n = 3'd2;
            default:                n = 3'd0;
        endcase
        return n;
    endfunction

    // Re-extend right-justified read data according to the load size.
    function automatic logic [31:0] extend_rdata(input logic [2:0] size, input logic [31:0] raw);
        logic [31:0] ext;
        case (size)
            SIZE_BYTE:   ext = {{24{raw[7]}}, raw[7:0]};
            SIZE_HALF:   ext = {{16{raw[15]}}, raw[15:0]};
            SIZE_BYTE_U: ext = {24'd0, raw[7:0]};
            SIZE_HALF_U: ext = {16'd0, raw[15:0]};
            default:     ext = raw;
        endcase
        return ext;
    endfunction

endpackage

// File: rtl/mem_access_check.sv
// Combinational legality check of one memory access: flags unsupported size
// codes, misaligned halfword/word accesses and accesses running past the end
// of the attached memory.
module mem_access_check
    import riscv_mem_pkg::*;
#(
    parameter int unsigned MEMORY_SIZE = 256
) (
    input  logic [31:0] addr,
    input  logic [2:0]  size,
    output logic        err
);

    logic [2:0]  nbytes_s;
    logic [32:0] last_byte_s;
    logic        misaligned_s;

    // Evaluate alignment and range; the last byte is computed one bit wider so
    // addresses near 2^32 cannot wrap back into range.
    always_comb begin
        nbytes_s = size_nbytes(size);
        case (size)
            SIZE_WORD:              misaligned_s = (addr[1:0] != 2'b00);
            SIZE_HALF, SIZE_HALF_U: misaligned_s = addr[0];
            default:                misaligned_s = 1'b0;
        endcase
        last_byte_s = {1'b0, addr} + {30'd0, nbytes_s} - 33'd1;
        err = (nbytes_s == 3'd0) | misaligned_s | (last_byte_s >= 33'(MEMORY_SIZE));
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single unified memory between instruction fetch (IF) and
// load/store (D). One grant per cycle, combinational memory drive, registered
// responses one cycle after the grant. D normally wins; IF wins one contested
// grant after STARVE_LIMIT consecutive denials.
module mem_port_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int unsigned MEMORY_SIZE  = 256,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [2:0]  d_size,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic [2:0]  mem_size,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned        CNT_W    = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0]   CNT_TRIP = CNT_W'(STARVE_LIMIT - 1);

    arb_state_e       state_r;
    arb_state_e       state_nxt_s;
    logic [CNT_W-1:0] starve_cnt_r;
    logic [CNT_W-1:0] starve_cnt_nxt_s;
    logic [31:0]      sel_addr_s;
    logic [2:0]       sel_size_s;
    logic             access_err_s;

    // Grant decision: nothing while RESET is high, otherwise the priority
    // state breaks ties when both ports request.
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (RESET) begin
            if_gnt = 1'b0;
            d_gnt  = 1'b0;
        end else if (if_req && d_req) begin
            if (state_r == I_PRI) begin
                if_gnt = 1'b1;
            end else begin
                d_gnt = 1'b1;
            end
        end else if (if_req) begin
            if_gnt = 1'b1;
        end else if (d_req) begin
            d_gnt = 1'b1;
        end else begin
            if_gnt = 1'b0;
            d_gnt  = 1'b0;
        end
    end

    // Memory request mux: the granted port drives the memory, idle forces a
    // harmless word read of address 0.
    always_comb begin
        sel_addr_s = 32'd0;
        sel_size_s = SIZE_WORD;
        mem_wdata  = 32'd0;
        if (if_gnt) begin
            sel_addr_s = if_addr;
            sel_size_s = SIZE_WORD;
        end else if (d_gnt) begin
            sel_addr_s = d_addr;
            sel_size_s = d_size;
            mem_wdata  = d_wdata;
        end else begin
            sel_addr_s = 32'd0;
            sel_size_s = SIZE_WORD;
        end
    end

    mem_access_check #(
        .MEMORY_SIZE (MEMORY_SIZE)
    ) u_access_check (
        .addr (sel_addr_s),
        .size (sel_size_s),
        .err  (access_err_s)
    );

    assign mem_addr = sel_addr_s;
    assign mem_size = sel_size_s;
    // A rejected store must never reach the array.
    assign mem_we   = d_gnt & d_we & ~access_err_s;

    // Priority and starvation bookkeeping: count consecutive IF denials and
    // hand IF the tie-break once the limit is reached, until IF is served.
    always_comb begin
        state_nxt_s      = state_r;
        starve_cnt_nxt_s = starve_cnt_r;
        if (if_gnt) begin
            starve_cnt_nxt_s = '0;
            state_nxt_s      = D_PRI;
        end else if (if_req) begin
            if (starve_cnt_r != CNT_MAX) begin
                starve_cnt_nxt_s = starve_cnt_r + 1'b1;
            end else begin
                starve_cnt_nxt_s = starve_cnt_r;
            end
            if ((state_r == D_PRI) && (starve_cnt_r == CNT_TRIP)) begin
                state_nxt_s = I_PRI;
            end else begin
                state_nxt_s = state_r;
            end
        end else begin
            starve_cnt_nxt_s = '0;
        end
    end

    // Arbiter state register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r      <= D_PRI;
            starve_cnt_r <= '0;
        end else begin
            state_r      <= state_nxt_s;
            starve_cnt_r <= starve_cnt_nxt_s;
        end
    end

    // Fetch response: one-cycle valid pulse, data captured at the grant edge.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            if_rvalid <= 1'b0;
            if_err    <= 1'b0;
            if_rdata  <= 32'd0;
        end else begin
            if_rvalid <= if_gnt;
            if_err    <= if_gnt & access_err_s;
            if_rdata  <= (if_gnt && !access_err_s) ? mem_rdata : 32'd0;
        end
    end

    // Load/store response: loads return extended data, stores and errors return 0.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            d_rvalid <= 1'b0;
            d_err    <= 1'b0;
            d_rdata  <= 32'd0;
        end else begin
            d_rvalid <= d_gnt;
            d_err    <= d_gnt & access_err_s;
            d_rdata  <= (d_gnt && !d_we && !access_err_s) ? extend_rdata(d_size, mem_rdata) : 32'd0;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: big-endian byte memory model behind the port,
// reference model of arbitration and access rules, scoreboard queues of
// expected responses drained by an independent monitor.
module tb_mem_port_arbiter;
    import riscv_mem_pkg::*;

    localparam int MEM_SZ = 256;
    localparam int LIMIT  = 4;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic        if_gnt, if_rvalid, if_err;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0, d_we = 1'b0;
    logic [31:0] d_addr = 32'd0, d_wdata = 32'd0;
    logic [2:0]  d_size = 3'd0;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] d_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;
    logic [2:0]  mem_size;

    mem_port_arbiter #(.MEMORY_SIZE(MEM_SZ), .STARVE_LIMIT(LIMIT)) dut (
        .CLK(CLK), .RESET(RESET),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_size(mem_size),
        .mem_rdata(mem_rdata)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(negedge CLK) cyc <= cyc + 1;

    // ---------------- memory behind the port ----------------
    logic [7:0] tbm  [0:MEM_SZ-1];
    logic [7:0] refm [0:MEM_SZ-1];
    logic       load_mem = 1'b0;
    logic [7:0] ma;
    assign ma = mem_addr[7:0];

    always_comb begin
        case (mem_size)
            3'd0: mem_rdata = {tbm[ma], tbm[ma + 8'd1], tbm[ma + 8'd2], tbm[ma + 8'd3]};
            3'd1: mem_rdata = {{24{tbm[ma][7]}}, tbm[ma]};
            3'd2: mem_rdata = {{16{tbm[ma][7]}}, tbm[ma], tbm[ma + 8'd1]};
            3'd3: mem_rdata = {24'd0, tbm[ma]};
            3'd4: mem_rdata = {16'd0, tbm[ma], tbm[ma + 8'd1]};
            default: mem_rdata = 32'd0;
        endcase
    end

    always @(posedge CLK) begin
        if (load_mem) begin
            for (int i = 0; i < MEM_SZ; i++) tbm[i] <= refm[i];
        end else if (mem_we) begin
            case (mem_size)
                3'd0: begin
                    tbm[ma] <= mem_wdata[31:24]; tbm[ma + 8'd1] <= mem_wdata[23:16];
                    tbm[ma + 8'd2] <= mem_wdata[15:8]; tbm[ma + 8'd3] <= mem_wdata[7:0];
                end
                3'd1, 3'd3: tbm[ma] <= mem_wdata[7:0];
                3'd2, 3'd4: begin tbm[ma] <= mem_wdata[15:8]; tbm[ma + 8'd1] <= mem_wdata[7:0]; end
                default: ;
            endcase
        end
    end

    // ---------------- checking infrastructure ----------------
    int checks = 0;
    int passes = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail_now(input string name);
        checks++;
        $display("FAIL %s: expected event did not occur (cycle %0d)", name, cyc);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          tag;
        logic        err;
        logic [31:0] data;
    } resp_t;

    resp_t iq[$];
    resp_t dq[$];
    int    denials = 0;

    function automatic int nbytes(input logic [2:0] size);
        if (size == 3'd0) return 4;
        if (size == 3'd1 || size == 3'd3) return 1;
        if (size == 3'd2 || size == 3'd4) return 2;
        return 0;
    endfunction

    function automatic logic exp_err(input logic [31:0] addr, input logic [2:0] size);
        int     n;
        longint last;
        n = nbytes(size);
        if (n == 0) return 1'b1;
        if ((longint'(addr) % n) != 0) return 1'b1;
        last = longint'(addr) + n - 1;
        return (last >= MEM_SZ);
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] addr, input logic [2:0] size);
        int n, base, v;
        n = nbytes(size);
        base = int'(addr);
        v = 0;
        for (int i = 0; i < n; i++) v = (v << 8) | int'(refm[base + i]);
        if (size == 3'd1 && v >= 128) v = v - 256;
        if (size == 3'd2 && v >= 32768) v = v - 65536;
        return 32'(v);
    endfunction

    task automatic ref_write(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wd);
        int n, base;
        n = nbytes(size);
        base = int'(addr);
        for (int i = 0; i < n; i++) refm[base + i] = 8'(wd >> (8 * (n - 1 - i)));
    endtask

    // staged request fields, driven onto the DUT at the next falling edge
    logic        n_ir = 1'b0, n_dr = 1'b0, n_dwe = 1'b0;
    logic [31:0] n_ia = 32'd0, n_da = 32'd0, n_dwd = 32'd0;
    logic [2:0]  n_dsz = 3'd0;
    logic        ig, dg;

    task automatic step(output logic oig, output logic odg);
        logic        eig, edg, err, ewe;
        logic [31:0] ea;
        logic [2:0]  es;
        resp_t       r;
        @(negedge CLK);
        if_req = n_ir; if_addr = n_ia;
        d_req = n_dr; d_we = n_dwe; d_addr = n_da; d_wdata = n_dwd; d_size = n_dsz;
        #1;
        eig = n_ir && (!n_dr || denials >= LIMIT);
        edg = n_dr && !eig;
        check1("if_gnt", if_gnt, eig);
        check1("d_gnt", d_gnt, edg);
        ea = 32'd0; es = 3'd0; ewe = 1'b0; err = 1'b0;
        if (eig) begin
            ea = n_ia; err = exp_err(n_ia, 3'd0);
        end else if (edg) begin
            ea = n_da; es = n_dsz; err = exp_err(n_da, n_dsz); ewe = n_dwe && !err;
        end
        check32("mem_addr", mem_addr, ea);
        check32("mem_size", {29'd0, mem_size}, {29'd0, es});
        check1("mem_we", mem_we, ewe);
        if (edg && n_dwe) check32("mem_wdata", mem_wdata, n_dwd);
        r.tag = cyc;
        r.err = err;
        if (eig) begin
            r.data = err ? 32'd0 : ref_read(n_ia, 3'd0);
            iq.push_back(r);
        end
        if (edg) begin
            if (n_dwe) begin
                if (!err) ref_write(n_da, n_dsz, n_dwd);
                r.data = 32'd0;
            end else begin
                r.data = err ? 32'd0 : ref_read(n_da, n_dsz);
            end
            dq.push_back(r);
        end
        denials = (n_ir && !eig) ? denials + 1 : 0;
        oig = eig;
        odg = edg;
    endtask

    // ---------------- monitor ----------------
    initial begin
        resp_t r;
        forever begin
            @(negedge CLK);
            #2;
            while (iq.size() > 0 && iq[0].tag < cyc - 1) begin
                fail_now("if_rvalid_missing");
                void'(iq.pop_front());
            end
            if (iq.size() > 0 && iq[0].tag == cyc - 1) begin
                r = iq.pop_front();
                check1("if_rvalid", if_rvalid, 1'b1);
                check1("if_err", if_err, r.err);
                check32("if_rdata", if_rdata, r.data);
            end else begin
                check1("if_rvalid_idle", if_rvalid, 1'b0);
            end
            while (dq.size() > 0 && dq[0].tag < cyc - 1) begin
                fail_now("d_rvalid_missing");
                void'(dq.pop_front());
            end
            if (dq.size() > 0 && dq[0].tag == cyc - 1) begin
                r = dq.pop_front();
                check1("d_rvalid", d_rvalid, 1'b1);
                check1("d_err", d_err, r.err);
                check32("d_rdata", d_rdata, r.data);
            end else begin
                check1("d_rvalid_idle", d_rvalid, 1'b0);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic do_reset(input int n);
        @(negedge CLK);
        RESET = 1'b1;
        if_req = 1'b1; if_addr = 32'd0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'hA5A5A5A5; d_size = SIZE_WORD;
        #1;
        iq.delete();
        dq.delete();
        denials = 0;
        check1("rst_d_rvalid", d_rvalid, 1'b0);
        check1("rst_if_rvalid", if_rvalid, 1'b0);
        check1("rst_if_gnt", if_gnt, 1'b0);
        check1("rst_d_gnt", d_gnt, 1'b0);
        check1("rst_mem_we", mem_we, 1'b0);
        repeat (n) @(negedge CLK);
        RESET = 1'b0;
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        n_ir = 1'b0; n_dr = 1'b0; n_dwe = 1'b0;
    endtask

    task automatic d_access(input logic we, input logic [31:0] addr, input logic [31:0] wd, input logic [2:0] sz);
        logic got;
        n_dr = 1'b1; n_dwe = we; n_da = addr; n_dwd = wd; n_dsz = sz;
        got = 1'b0;
        for (int k = 0; k < 16 && !got; k++) begin
            step(ig, dg);
            got = dg;
        end
        if (!got) fail_now("d_grant_timeout");
        n_dr = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] addr);
        logic got;
        n_ir = 1'b1; n_ia = addr;
        got = 1'b0;
        for (int k = 0; k < 16 && !got; k++) begin
            step(ig, dg);
            got = ig;
        end
        if (!got) fail_now("if_grant_timeout");
        n_ir = 1'b0;
    endtask

    task automatic d_expect(input string name, input logic [31:0] data, input logic err);
        step(ig, dg);
        check1({name, "_rvalid"}, d_rvalid, 1'b1);
        check1({name, "_err"}, d_err, err);
        check32({name, "_rdata"}, d_rdata, data);
    endtask

    task automatic if_expect(input string name, input logic err);
        step(ig, dg);
        check1({name, "_rvalid"}, if_rvalid, 1'b1);
        check1({name, "_err"}, if_err, err);
    endtask

    // Both ports held from a fresh D_PRI state: D for LIMIT cycles, then IF once.
    task automatic starve_pattern(input string name);
        n_ir = 1'b1; n_ia = 32'h4;
        n_dr = 1'b1; n_dwe = 1'b0; n_da = 32'h40; n_dsz = SIZE_WORD;
        for (int k = 0; k < LIMIT + 2; k++) begin
            step(ig, dg);
            check1({name, "_if_gnt"}, if_gnt, k == LIMIT);
            check1({name, "_d_gnt"}, d_gnt, k != LIMIT);
        end
        n_ir = 1'b0; n_dr = 1'b0;
        step(ig, dg);
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 7))
            0: return 32'($urandom_range(248, 263));
            7: return $urandom();
            default: return 32'($urandom_range(0, 255));
        endcase
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        for (int i = 0; i < MEM_SZ; i++) refm[i] = 8'($urandom_range(0, 255));
        refm[0] = 8'h00; refm[1] = 8'h00; refm[2] = 8'h00; refm[3] = 8'h93;
        load_mem = 1'b1;
        do_reset(3);
        load_mem = 1'b0;

        // lone fetch of address 0
        n_ir = 1'b1; n_ia = 32'd0;
        step(ig, dg);
        check1("t1_if_gnt", if_gnt, 1'b1);
        n_ir = 1'b0;
        step(ig, dg);
        check1("t1_if_rvalid", if_rvalid, 1'b1);
        check32("t1_if_rdata", if_rdata, 32'h00000093);

        starve_pattern("t2");

        // store then signed/unsigned byte loads
        d_access(1'b1, 32'h40, 32'hDEADBEEF, SIZE_WORD);
        d_expect("t3_store", 32'd0, 1'b0);
        d_access(1'b0, 32'h40, 32'd0, SIZE_BYTE);
        d_expect("t3_lb", 32'hFFFFFFDE, 1'b0);
        d_access(1'b0, 32'h40, 32'd0, SIZE_BYTE_U);
        d_expect("t3_lbu", 32'h000000DE, 1'b0);

        // misaligned accesses leave memory alone
        d_access(1'b0, 32'h42, 32'd0, SIZE_WORD);
        d_expect("t4_lw_mis", 32'd0, 1'b1);
        d_access(1'b1, 32'h41, 32'h00001234, SIZE_HALF);
        d_expect("t4_sh_mis", 32'd0, 1'b1);
        d_access(1'b0, 32'h40, 32'd0, SIZE_WORD);
        d_expect("t4_reread", 32'hDEADBEEF, 1'b0);

        // fetch range boundary
        fetch(32'hFC);
        if_expect("t5_fetch_fc", 1'b0);
        fetch(32'h100);
        if_expect("t5_fetch_100", 1'b1);
        check32("t5_fetch_100_rdata", if_rdata, 32'd0);

        // reset right after a store grant, with the arbiter already in IF priority
        n_ir = 1'b1; n_ia = 32'h8;
        n_dr = 1'b1; n_dwe = 1'b1; n_da = 32'h44; n_dwd = 32'h0BADF00D; n_dsz = SIZE_WORD;
        for (int k = 0; k < LIMIT; k++) step(ig, dg);
        do_reset(2);
        starve_pattern("t6");
        d_access(1'b0, 32'h80, 32'd0, SIZE_WORD);
        d_access(1'b0, 32'h44, 32'd0, SIZE_WORD);
        step(ig, dg);

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            if (!n_ir && $urandom_range(0, 3) != 0) begin
                n_ir = 1'b1; n_ia = rand_addr();
            end
            if (!n_dr && $urandom_range(0, 3) != 0) begin
                n_dr = 1'b1;
                n_dwe = 1'($urandom_range(0, 1));
                n_da = rand_addr();
                n_dwd = $urandom();
                n_dsz = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
            end
            step(ig, dg);
            if (ig) n_ir = 1'b0;
            if (dg) n_dr = 1'b0;
        end

        n_ir = 1'b0; n_dr = 1'b0;
        repeat (3) step(ig, dg);
        if (iq.size() != 0) fail_now("if_responses_outstanding");
        if (dq.size() != 0) fail_now("d_responses_outstanding");
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, %0d/%0d comparisons matched", passes, checks);
        $fatal(1, "time limit reached");
    end

endmodule
